// File: rtl/sram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter_pkg
// Shared definitions for the two-requester SRAM port arbiter:
//   - state_e      : transaction FSM encoding (IDLE, LOW, HIGH, DONE)
//   - M0 / M1      : requester index constants
//   - ADDR_BASE_DEF, HALF_CYCLES_DEF : parameter defaults
//   - word_addr()  : byte address -> 17-bit SRAM word index
// -----------------------------------------------------------------------------
package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam logic [31:0] ADDR_BASE_DEF   = 32'd1024;
   localparam int          HALF_CYCLES_DEF = 2;

   // Offset from the base wraps modulo 2^32; only the low 17 word bits reach
   // the SRAM, so out-of-window addresses alias instead of faulting.
   function automatic logic [16:0] word_addr(input logic [31:0] i_addr,
                                             input logic [31:0] i_base);
      return 17'((i_addr - i_base) >> 32'd2);
   endfunction

endpackage

// File: rtl/sram_port_arbiter_grant_sel.sv
// -----------------------------------------------------------------------------
// sram_grant_sel
// Chooses which requester is granted when the arbiter leaves IDLE.
// Ports:
//   i_req0, i_req1  : requests from requester 0 / 1
//   i_last_grant    : index granted by the previous transaction
//   o_grant         : index to grant (M0 / M1)
// Configuration macro: SRAM_ARB_ROUND_ROBIN_EN
//   defined   -> simultaneous requests alternate away from i_last_grant
//   undefined -> requester 0 has fixed priority, i_last_grant is ignored
// -----------------------------------------------------------------------------
module sram_grant_sel
   import sram_port_arbiter_pkg::*;
(
   input  logic i_req0,
   input  logic i_req1,
   input  logic i_last_grant,
   output logic o_grant
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   // Round-robin pick: a contested grant goes to whoever did not win last
   always_comb begin
      o_grant = M0;
      if (i_req0 && i_req1) begin
         o_grant = (i_last_grant == M0) ? M1 : M0;
      end else if (i_req1) begin
         o_grant = M1;
      end else begin
         o_grant = M0;
      end
   end
`else
   logic w_unused_last_grant;
   assign w_unused_last_grant = i_last_grant;

   // Fixed-priority pick: requester 0 always wins a contested grant
   always_comb begin
      o_grant = M0;
      if (i_req0) begin
         o_grant = M0;
      end else if (i_req1) begin
         o_grant = M1;
      end else begin
         o_grant = M0;
      end
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// sram_port_arbiter
// Shares one 16-bit asynchronous SRAM between two 32-bit requesters. Each
// transaction is two half-word accesses (low half, then high half), each held
// HALF_CYCLES cycles, followed by a one-cycle DONE where ready pulses.
// Ports:
//   clk, rst                 : clock (rising edge), async active-low reset
//   mX_req/we/addr/wdata     : requester X transaction request
//   mX_rdata, mX_ready       : registered read data, completion pulse
//   SRAM_DQ/ADDR/*_N         : SRAM bus and active-low controls
//   busy                     : transaction in progress
// Configuration macro: SRAM_ARB_ROUND_ROBIN_EN (round-robin on contention;
// default build is fixed priority to requester 0 with no last-grant register).
// -----------------------------------------------------------------------------
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
   parameter int          HALF_CYCLES = HALF_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        busy
);

   localparam int             CW        = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;
   localparam logic [CW-1:0]  CNT_ZERO  = CW'(1'b0);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1'b1);
   localparam logic [CW-1:0]  CNT_MAX   = CW'(HALF_CYCLES - 1);

   state_e        r_state;
   state_e        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic          r_grant;
   logic          r_we;
   logic [16:0]   r_waddr;
   logic [31:0]   r_wdata;
   logic [15:0]   r_rlo;
   logic [31:0]   r_m0_rdata;
   logic [31:0]   r_m1_rdata;

   logic          w_grant;
   logic          w_last_grant;
   logic          w_any_req;
   logic          w_start;
   logic          w_half_end;
   logic          w_in_access;
   logic          w_lo_capture;
   logic          w_hi_capture;
   logic          w_dq_oe;
   logic [15:0]   w_dq_out;

   assign w_any_req    = m0_req | m1_req;
   assign w_start      = (r_state == IDLE) && w_any_req;
   assign w_half_end   = (r_cnt == CNT_MAX);
   assign w_in_access  = (r_state == LOW) || (r_state == HIGH);
   assign w_lo_capture = (r_state == LOW)  && w_half_end && !r_we;
   assign w_hi_capture = (r_state == HIGH) && w_half_end && !r_we;

   sram_grant_sel u_grant_sel (
      .i_req0       (m0_req),
      .i_req1       (m1_req),
      .i_last_grant (w_last_grant),
      .o_grant      (w_grant)
   );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic r_last_grant;

   // Last-grant history, refreshed whenever a transaction is accepted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= M1;
      end else if (w_start) begin
         r_last_grant <= w_grant;
      end
   end
   assign w_last_grant = r_last_grant;
`else
   assign w_last_grant = M1;
`endif

   // Next-state logic; requests outside IDLE are deliberately ignored
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    w_state_nxt = w_any_req  ? LOW  : IDLE;
         LOW:     w_state_nxt = w_half_end ? HIGH : LOW;
         HIGH:    w_state_nxt = w_half_end ? DONE : HIGH;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, half counter, transaction latch and read-data registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_cnt      <= CNT_ZERO;
         r_grant    <= M0;
         r_we       <= 1'b0;
         r_waddr    <= 17'd0;
         r_wdata    <= 32'd0;
         r_rlo      <= 16'd0;
         r_m0_rdata <= 32'd0;
         r_m1_rdata <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         // Counter restarts on every state change so each half gets a full count
         if (w_state_nxt != r_state) begin
            r_cnt <= CNT_ZERO;
         end else if (w_in_access) begin
            r_cnt <= r_cnt + CNT_ONE;
         end else begin
            r_cnt <= CNT_ZERO;
         end
         // Inputs are frozen here so the requester may change them afterwards
         if (w_start) begin
            r_grant <= w_grant;
            r_we    <= (w_grant == M1) ? m1_we : m0_we;
            r_waddr <= word_addr((w_grant == M1) ? m1_addr : m0_addr, ADDR_BASE);
            r_wdata <= (w_grant == M1) ? m1_wdata : m0_wdata;
         end
         if (w_lo_capture) begin
            r_rlo <= SRAM_DQ;
         end
         if (w_hi_capture && (r_grant == M0)) begin
            r_m0_rdata <= {SRAM_DQ, r_rlo};
         end
         if (w_hi_capture && (r_grant == M1)) begin
            r_m1_rdata <= {SRAM_DQ, r_rlo};
         end
      end
   end

   // SRAM address, strobes and data-drive decode from the current state
   always_comb begin
      SRAM_ADDR = 18'd0;
      SRAM_WE_N = 1'b1;
      SRAM_OE_N = 1'b1;
      SRAM_CE_N = 1'b1;
      w_dq_oe   = 1'b0;
      w_dq_out  = 16'd0;
      case (r_state)
         LOW, HIGH: begin
            SRAM_ADDR = {r_waddr, (r_state == HIGH)};
            SRAM_CE_N = 1'b0;
            if (r_we) begin
               SRAM_WE_N = 1'b0;
               w_dq_oe   = 1'b1;
               w_dq_out  = (r_state == HIGH) ? r_wdata[31:16] : r_wdata[15:0];
            end else begin
               SRAM_OE_N = 1'b0;
            end
         end
         default: begin
            SRAM_ADDR = 18'd0;
         end
      endcase
   end

   assign SRAM_DQ   = w_dq_oe ? w_dq_out : 16'bz;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign busy      = (r_state != IDLE);
   assign m0_ready  = (r_state == DONE) && (r_grant == M0);
   assign m1_ready  = (r_state == DONE) && (r_grant == M1);
   assign m0_rdata  = r_m0_rdata;
   assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_port_arbiter
// Self-checking bench: a transaction-level model (cycle index inside the
// current transaction, latched request, SRAM contents) predicts every DUT
// output each cycle; directed scenarios add literal expectations.
// The SRAM model drives DQ whenever the DUT must not, with a known value,
// so any stray DUT drive shows up as a corrupted bus value.
// -----------------------------------------------------------------------------
module tb_sram_port_arbiter;

   localparam logic [31:0] BASE = 32'd1024;
   localparam int          H    = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [31:0] m0_addr = 32'd0, m0_wdata = 32'd0, m1_addr = 32'd0, m1_wdata = 32'd0;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   wire  [15:0] sram_dq;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N, busy;

   logic        tb_dq_en  = 1'b1;
   logic [15:0] tb_dq_val = 16'h0000;
   assign sram_dq = tb_dq_en ? tb_dq_val : 16'bz;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_BASE(BASE), .HALF_CYCLES(H)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .SRAM_DQ(sram_dq), .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N),
      .SRAM_LB_N(SRAM_LB_N), .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N),
      .SRAM_OE_N(SRAM_OE_N), .busy(busy)
   );

   // ---------------- behavioural model ----------------
   bit          m_act;
   int          m_t;       // 1..2H+1 = cycle number within the transaction
   bit          m_g, m_we, m_last;
   logic [31:0] m_addr, m_wdata;
   logic [31:0] m_rd [2];
   logic [15:0] mem [logic [17:0]];

   function automatic logic [15:0] mem_rd(input logic [17:0] a);
      if (mem.exists(a)) return mem[a];
      return a[15:0] ^ 16'h5A3C;
   endfunction

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return (a - BASE) >> 2;
   endfunction

   // 0 = idle, 1 = low half, 2 = high half, 3 = done cycle
   function automatic int phase();
      if (!m_act) return 0;
      if (m_t <= H) return 1;
      if (m_t <= 2 * H) return 2;
      return 3;
   endfunction

   function automatic logic [17:0] exp_sa();
      logic [31:0] w;
      w = word_of(m_addr);
      case (phase())
         1: return {w[16:0], 1'b0};
         2: return {w[16:0], 1'b1};
         default: return 18'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_act = 1'b0; m_t = 0; m_rd[0] = 32'd0; m_rd[1] = 32'd0; m_last = 1'b1;
   endtask

   // Advance the model over one clock edge using the inputs present at it
   task automatic model_step();
      logic [31:0] w;
      bit g;
      if (!rst) begin
         model_reset();
         return;
      end
      if (m_act) begin
         if (m_t == 2 * H) begin
            w = word_of(m_addr);
            if (m_we) begin
               mem[{w[16:0], 1'b0}] = m_wdata[15:0];
               mem[{w[16:0], 1'b1}] = m_wdata[31:16];
            end else begin
               m_rd[m_g] = {mem_rd({w[16:0], 1'b1}), mem_rd({w[16:0], 1'b0})};
            end
         end
         if (m_t == 2 * H + 1) m_act = 1'b0;
         else m_t = m_t + 1;
      end else if (m0_req || m1_req) begin
         if (m0_req && m1_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            g = ~m_last;
`else
            g = 1'b0;
`endif
         end else begin
            g = m1_req;
         end
         m_last  = g;
         m_g     = g;
         m_we    = g ? m1_we : m0_we;
         m_addr  = g ? m1_addr : m0_addr;
         m_wdata = g ? m1_wdata : m0_wdata;
         m_act   = 1'b1;
         m_t     = 1;
      end
   endtask

   task automatic update_bus();
      int p;
      p = phase();
      if ((p == 1 || p == 2) && m_we) begin
         tb_dq_en = 1'b0; tb_dq_val = 16'h0000;
      end else if (p == 1 || p == 2) begin
         tb_dq_en = 1'b1; tb_dq_val = mem_rd(exp_sa());
      end else begin
         tb_dq_en = 1'b1; tb_dq_val = 16'h0000;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Cycle-by-cycle comparison of every DUT output against the model
   task automatic compare_all();
      int p;
      bit acc;
      p   = phase();
      acc = (p == 1 || p == 2);
      chk("busy", busy, m_act);
      chk("sram_addr", SRAM_ADDR, exp_sa());
      chk("ce_n", SRAM_CE_N, !acc);
      chk("we_n", SRAM_WE_N, !(acc && m_we));
      chk("oe_n", SRAM_OE_N, !(acc && !m_we));
      chk("ub_lb_n", {SRAM_UB_N, SRAM_LB_N}, 2'b00);
      chk("m0_ready", m0_ready, (p == 3) && (m_g == 1'b0));
      chk("m1_ready", m1_ready, (p == 3) && (m_g == 1'b1));
      chk("m0_rdata", m0_rdata, m_rd[0]);
      chk("m1_rdata", m1_rdata, m_rd[1]);
      if (acc && m_we) chk("dq_write", sram_dq, (p == 1) ? m_wdata[15:0] : m_wdata[31:16]);
      else             chk("dq_undriven", sram_dq, tb_dq_val);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      model_step();
      update_bus();
      #1;
      compare_all();
   endtask

   // ---------------- random requesters ----------------
   bit          pend [2];
   logic        rwe  [2];
   logic [31:0] raddr[2];
   logic [31:0] rwd  [2];

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 3))
         0: return $urandom;
         1: return BASE - 32'($urandom_range(1, 64));
         default: return BASE + 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(0, 3));
      endcase
   endfunction

   initial begin
      int n;
      bit seq [4];
      bit exp_g [4];
      bit got;

      model_reset();
      repeat (3) tick();
      rst = 1'b1;
      tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_m0_rdata", m0_rdata, 32'd0);
      chk("rst_ce_n", SRAM_CE_N, 1'b1);

      // m0 write 0xDEADBEEF to 1024
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd1024; m0_wdata = 32'hDEADBEEF;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k <= 4) begin
            chk("w_addr", SRAM_ADDR, (k <= 2) ? 18'h00000 : 18'h00001);
            chk("w_dq", sram_dq, (k <= 2) ? 16'hBEEF : 16'hDEAD);
            chk("w_we_n", SRAM_WE_N, 1'b0);
         end else begin
            chk("w_ready", m0_ready, 1'b1);
            m0_req = 1'b0; m0_wdata = 32'd0;
         end
      end
      tick();
      chk("w_idle_busy", busy, 1'b0);

      // m1 read of 1028 with halves 0x1234 / 0x5678
      mem[18'd2] = 16'h1234; mem[18'd3] = 16'h5678;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd1028;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k <= 4) chk("r_oe_n", SRAM_OE_N, 1'b0);
      end
      chk("r_ready", m1_ready, 1'b1);
      chk("r_m1_rdata", m1_rdata, 32'h56781234);
      chk("r_m0_rdata", m0_rdata, 32'd0);
      m1_req = 1'b0;
      tick();

      // m0 read of 1020 (below base) with req dropped after cycle 1
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1020;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) m0_req = 1'b0;
         if (k <= 4) chk("neg_addr", SRAM_ADDR, (k <= 2) ? 18'h3FFFE : 18'h3FFFF);
      end
      chk("neg_ready", m0_ready, 1'b1);
      chk("neg_rdata", m0_rdata, 32'hA5C3A5C2);
      tick();

      // reset in cycle 2 of an m0 write, then an m1 read
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = BASE + 32'd16; m0_wdata = 32'h11223344;
      tick();
      tick();
      #2;
      rst = 1'b0;
      model_reset();
      update_bus();
      #1;
      chk("ar_we_n", SRAM_WE_N, 1'b1);
      chk("ar_ce_n", SRAM_CE_N, 1'b1);
      chk("ar_oe_n", SRAM_OE_N, 1'b1);
      chk("ar_busy", busy, 1'b0);
      chk("ar_ready", m0_ready, 1'b0);
      chk("ar_addr", SRAM_ADDR, 18'd0);
      chk("ar_dq", sram_dq, 16'h0000);
      chk("ar_m1_rdata", m1_rdata, 32'd0);
      m0_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      mem[18'd4] = 16'hAAAA; mem[18'd5] = 16'h5555;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = BASE + 32'd8;
      for (int k = 1; k <= 5; k++) tick();
      chk("ar2_ready", m1_ready, 1'b1);
      chk("ar2_rdata", m1_rdata, 32'h5555AAAA);
      m1_req = 1'b0;
      tick();

      // both requesters continuously for four transactions
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = BASE;
      m1_req = 1'b1; m1_we = 1'b0; m1_addr = BASE + 32'd8;
      n = 0;
      for (int k = 0; k < 40 && n < 4; k++) begin
         tick();
         if (m0_ready || m1_ready) begin
            seq[n] = m1_ready;
            n++;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      chk("arb_count", n, 4);
      for (int k = 0; k < n; k++) begin
         got = seq[k];
         chk("arb_grant", got, exp_g[k]);
      end
      tick();

      // randomized traffic
      for (int i = 0; i < 2; i++) pend[i] = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         for (int i = 0; i < 2; i++) begin
            if (pend[i] && phase() == 3 && m_g == 1'(i)) begin
               pend[i] = 1'b0;
            end else if (pend[i] && $urandom_range(0, 19) == 0) begin
               pend[i] = 1'b0;
            end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1; rwe[i] = 1'($urandom_range(0, 1));
               raddr[i] = rand_addr(); rwd[i] = $urandom;
            end else if (pend[i] && m_act && m_g == 1'(i) && $urandom_range(0, 3) == 0) begin
               rwe[i] = 1'($urandom_range(0, 1)); raddr[i] = rand_addr(); rwd[i] = $urandom;
            end
         end
         m0_req = pend[0]; m0_we = rwe[0]; m0_addr = raddr[0]; m0_wdata = rwd[0];
         m1_req = pend[1]; m1_we = rwe[1]; m1_addr = raddr[1]; m1_wdata = rwd[1];
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
